// File: rtl/demux_scan_sequencer.sv
// demux_scan_sequencer: drives the 3-bit select, data bit and enable of the
// 1-to-8 LED demultiplexer. The select walks through the outputs either
// automatically at a prescaled rate (RUN), one position per step-key press
// (HOLD), or not at all with the demux disabled (IDLE).
//
// Optional build macro SEQ_PINGPONG_EN: when defined, the dir input is
// ignored and the select bounces 0..max..0 using an internal direction flag
// instead of wrapping around.
//
// Handshake: adv is a one-cycle pulse that is high in exactly the cycle in
// which sel presents a new value; there is no back-pressure.
module demux_scan_sequencer #(
    parameter int unsigned DIV_MAX = 49999999,
    parameter int unsigned DIV_W   = 26,
    parameter int unsigned SEL_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             dir,
    input  logic             step,
    input  logic             data_in,
    output logic [SEL_W-1:0] sel,
    output logic             d_out,
    output logic             en_out,
    output logic             adv,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV_MAX);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [SEL_W-1:0]   sel_q, sel_d, sel_step;
    logic               adv_q, adv_d;
    logic               en_q, en_d;
    logic               d_q;
    logic               step_q;
    logic               step_rise;
    logic               do_adv;
    logic               adv_down;

`ifdef SEQ_PINGPONG_EN
    logic               down_q, down_d;
    logic               unused_dir;

    assign unused_dir = dir;
    assign adv_down   = down_q;
`else
    assign adv_down   = dir;
`endif

    assign step_rise = step & ~step_q;
    assign sel_step  = adv_down ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));

    // Next-state, prescaler and advance decision
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        do_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                end else if (step_rise) begin
                    state_d = HOLD;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = HOLD;
                end else if (presc_q == DIV_TC) begin
                    do_adv = 1'b1;
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            HOLD: begin
                // run has priority over a simultaneous step press
                if (run) begin
                    state_d = RUN;
                end else if (step_rise) begin
                    do_adv = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sel_d = do_adv ? sel_step : sel_q;
        adv_d = do_adv;
        en_d  = (state_d != IDLE);
    end

`ifdef SEQ_PINGPONG_EN
    // Flip the bounce direction whenever an advance lands on an end point
    always_comb begin
        down_d = down_q;
        if (do_adv) begin
            if (sel_step == '1) begin
                down_d = 1'b1;
            end else if (sel_step == '0) begin
                down_d = 1'b0;
            end
        end
    end

    // Bounce direction register, starts counting up
    always_ff @(posedge clk) begin
        if (rst) begin
            down_q <= 1'b0;
        end else begin
            down_q <= down_d;
        end
    end
`endif

    // State, prescaler and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            sel_q   <= '0;
            adv_q   <= 1'b0;
            en_q    <= 1'b0;
            d_q     <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            adv_q   <= adv_d;
            en_q    <= en_d;
            d_q     <= data_in;
            step_q  <= step;
        end
    end

    assign sel     = sel_q;
    assign adv     = adv_q;
    assign en_out  = en_q;
    assign d_out   = d_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// tb_demux_scan_sequencer: directed scenarios followed by randomized run/dir/
// step/data/reset traffic. A behavioural model pushes the expected outputs of
// every clock into a queue; an independent monitor pops and compares.
module tb_demux_scan_sequencer;

    localparam int DIV_MAX = 3;
    localparam int DIV_W   = 2;
    localparam int SEL_W   = 3;
    localparam int NPOS    = 1 << SEL_W;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic dir = 1'b0;
    logic step = 1'b0;
    logic data_in = 1'b0;

    logic [SEL_W-1:0] sel;
    logic             d_out;
    logic             en_out;
    logic             adv;
    logic [1:0]       state_o;

    always #5 clk = ~clk;

    demux_scan_sequencer #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .dir     (dir),
        .step    (step),
        .data_in (data_in),
        .sel     (sel),
        .d_out   (d_out),
        .en_out  (en_out),
        .adv     (adv),
        .state_o (state_o)
    );

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             en;
        logic             d;
        logic             adv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: mode 0 = idle, 1 = auto scan, 2 = manual stepping.
    // m_tick counts clocks spent in auto mode since the last advance/entry.
    int   m_mode = 0;
    int   m_tick = 0;
    int   m_sel  = 0;
    int   m_pos  = 0;
    logic m_step_prev = 1'b0;

    initial begin
        exp_t e;
        logic rise;
        logic a;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            e = '0;
            if (rst) begin
                m_mode = 0;
                m_tick = 0;
                m_sel = 0;
                m_pos = 0;
                m_step_prev = 1'b0;
            end else begin
                rise = step && !m_step_prev;
                m_step_prev = step;
                a = 1'b0;
                if (m_mode == 0) begin
                    if (run) begin
                        m_mode = 1;
                        m_tick = 0;
                    end else if (rise) begin
                        m_mode = 2;
                    end
                end else if (m_mode == 1) begin
                    if (!run) begin
                        m_mode = 2;
                    end else begin
                        m_tick = m_tick + 1;
                        if (m_tick == DIV_MAX + 1) begin
                            m_tick = 0;
                            a = 1'b1;
                        end
                    end
                end else begin
                    if (run) begin
                        m_mode = 1;
                        m_tick = 0;
                    end else if (rise) begin
                        a = 1'b1;
                    end
                end
                if (a) begin
`ifdef SEQ_PINGPONG_EN
                    m_pos = (m_pos + 1) % (2 * NPOS - 2);
                    m_sel = (m_pos < NPOS) ? m_pos : (2 * NPOS - 2 - m_pos);
`else
                    m_sel = dir ? (m_sel + NPOS - 1) % NPOS : (m_sel + 1) % NPOS;
`endif
                end
                e.sel = m_sel[SEL_W-1:0];
                e.en  = (m_mode != 0);
                e.d   = data_in;
                e.adv = a;
            end
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel", 8'(sel), 8'(e.sel));
                check("en_out", 8'(en_out), 8'(e.en));
                check("d_out", 8'(d_out), 8'(e.d));
                check("adv", 8'(adv), 8'(e.adv));
            end
        end
    end

    // Data bit changes every cycle in all phases
    initial begin
        forever begin
            @(negedge clk);
            data_in = 1'($urandom_range(0, 1));
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        step = 1'b1;
        tick(2);
        step = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Auto scan upward
        dir = 1'b0;
        run = 1'b1;
        tick(40);

        // Stop at position 5 and step manually across the wrap
        for (int i = 0; i < 64 && m_sel != 5; i++) tick(1);
        run = 1'b0;
        tick(2);
        repeat (3) press();

        // Step downward from 0, then resume auto scan downward
        dir = 1'b1;
        press();
        run = 1'b1;
        tick(12);

        // Reset in the middle of a prescaler period
        for (int i = 0; i < 16 && m_tick != 2; i++) tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        run = 1'b0;
        tick(3);
        press();
        press();
        tick(3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            dir  = 1'($urandom_range(0, 1));
            step = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0;
        run = 1'b0;
        step = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
